mma_launch_ctrl: RTL and testbench
==================================

Name: mma_launch_ctrl

Overview:
Core-side launch sequencer for the systolic MMA engine. It accepts tagged launch requests from the EAI/NICE command path, waits for the engine's `sa_ready`, and issues a single-cycle `calc_start`. It then acts as the consumer of the engine's `wb_valid`/`wb_ready`/`err_code` write-back handshake and returns a tagged completion response to the core. A cycle-based timeout reports a hung engine and safely drains any late write-back.

Parameters:
- TAG_WIDTH, 5, width of the request/response tag (core destination-register index).
- CNT_WIDTH, 32, width of the timeout and perf counters.
- TIMEOUT_CYCLES, 4096, cycles allowed in BUSY before a timeout error; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  launch request valid.
- req_ready  out  1  launch request accepted when high with req_valid.
- req_tag  in  TAG_WIDTH  tag echoed on the response.
- req_16bits_ia  in  1  input-activation width select for this launch.
- cfg_16bits_ia  out  1  registered copy of req_16bits_ia, driven to the engine.
- calc_start  out  1  single-cycle engine start pulse, registered.
- sa_ready  in  1  engine idle/ready.
- wb_valid  in  1  engine completion valid.
- wb_ready  out  1  completion accept.
- err_code  in  2  engine completion status.
- rsp_valid  out  1  completion response valid to core.
- rsp_ready  in  1  core accepts response.
- rsp_tag  out  TAG_WIDTH  latched req_tag.
- rsp_err  out  2  latched err_code, or 2'b11 on timeout.
- busy  out  1  high in any state other than IDLE, or while drain_pending.
- perf_last_cycles  out  CNT_WIDTH  cycles from calc_start to write-back of the last completed op (see Optional Feature).
- perf_launch_cnt  out  CNT_WIDTH  number of calc_start pulses issued (see Optional Feature).

Behaviour:
- Reset values: state=IDLE; calc_start=0; cfg_16bits_ia=0; rsp_valid=0; rsp_tag=0; rsp_err=0; drain_pending=0; counters=0.
- After reset, req_ready=1 and wb_ready=0, because both are combinational from state.
- States: IDLE, WAIT_RDY, BUSY, RESP.
- req_ready = (state==IDLE) && !drain_pending.
  - On acceptance, latch req_tag and req_16bits_ia, then go to WAIT_RDY.
- WAIT_RDY:
  - When sa_ready=1, set calc_start=1 for exactly one cycle on the next edge, clear the timeout counter, and go to BUSY.
  - When sa_ready=0, remain in WAIT_RDY indefinitely with no timeout.
- calc_start is never high for two consecutive cycles and is never asserted outside the WAIT_RDY→BUSY transition.
- BUSY:
  - wb_ready=1.
  - On wb_valid&&wb_ready: latch err_code into rsp_err, then go to RESP.
  - Otherwise, increment the timeout counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with no handshake: rsp_err=2'b11, set drain_pending, go to RESP.
  - If a handshake and the timeout coincide, the handshake wins and no timeout is reported.
- RESP:
  - rsp_valid=1; rsp_tag/rsp_err are stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE the following cycle.
  - Back-to-back minimum: req→calc_start latency is 2 cycles when sa_ready is already high.
- drain_pending:
  - While set, wb_ready=1 in every state.
  - The next wb_valid is consumed and discarded, and drain_pending clears.
  - New requests are blocked until it clears.
- wb_valid seen in IDLE/WAIT_RDY/RESP without drain_pending: wb_ready=0 and the beat is ignored (protocol violation; no state change).
- Reset mid-operation returns all state to reset values immediately; an in-flight response is lost.
- The counter saturates at its maximum and never wraps.

Optional Feature:
- Macro MMA_LAUNCH_PERF_EN.
- When defined:
  - perf_launch_cnt increments on each calc_start pulse and wraps modulo 2^CNT_WIDTH.
  - A cycle counter starts at 0 on the cycle after calc_start and increments each BUSY cycle.
  - On the wb handshake in BUSY, its value is copied to perf_last_cycles. Timeout does not update it.
- When undefined: both perf outputs are tied to 0 and no perf registers exist.

Test Plan:
1. Engine model with sa_ready=1 and a 10-cycle latency; req tag=5, 16bits_ia=1 → calc_start one pulse 2 cycles after request; cfg_16bits_ia=1; rsp_valid with rsp_tag=5, rsp_err=00; perf_launch_cnt=1 when the macro is on.
2. sa_ready held 0 for 20 cycles after the request → no calc_start and state stays WAIT_RDY; calc_start pulses once after sa_ready rises; busy=1 throughout.
3. Engine returns err_code=2'b01 and the core holds rsp_ready=0 for 5 cycles → rsp_valid, rsp_tag, rsp_err=01 stable for all 5 cycles; req_ready=0 until the handshake+1.
4. TIMEOUT_CYCLES=16 and engine never responds → rsp_err=11 after 16 BUSY cycles; a new request is blocked; a late wb_valid is accepted and discarded; req_ready returns to 1 the next cycle.
5. Assert rst for 1 cycle while in BUSY → calc_start=0, rsp_valid=0, wb_ready=0, req_ready=1 after deassertion.
6. Two back-to-back requests with rsp_ready tied high → exactly two calc_start pulses and two responses in order with matching tags.

Source files
------------

// File: rtl/mma_launch_ctrl.sv
// ============================================================================
// Module   : mma_launch_ctrl
// Purpose  : Launch sequencer for the systolic MMA engine: tagged request in,
//            single-cycle calc_start out, write-back consumed, tagged response
//            returned, with cycle timeout and drain of a late write-back.
// Options  : define MMA_LAUNCH_PERF_EN to enable the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mma_launch_ctrl #(
    parameter int TAG_WIDTH      = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 req_16bits_ia,
    output logic                 cfg_16bits_ia,
    output logic                 calc_start,
    input  logic                 sa_ready,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [1:0]           err_code,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [1:0]           rsp_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] perf_last_cycles,
    output logic [CNT_WIDTH-1:0] perf_launch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_BUSY     = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    localparam bit                 TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                 state_q;
    logic                   calc_start_q;
    logic                   cfg_16bits_ia_q;
    logic                   rsp_valid_q;
    logic [TAG_WIDTH-1:0]   rsp_tag_q;
    logic [1:0]             rsp_err_q;
    logic                   drain_pending_q;
    logic [CNT_WIDTH-1:0]   tmo_cnt_q;

`ifdef MMA_LAUNCH_PERF_EN
    logic [CNT_WIDTH-1:0]   perf_last_cycles_q;
    logic [CNT_WIDTH-1:0]   perf_launch_cnt_q;
`endif

    assign req_ready     = (state_q == ST_IDLE) && !drain_pending_q;
    assign wb_ready      = (state_q == ST_BUSY) || drain_pending_q;
    assign busy          = (state_q != ST_IDLE) || drain_pending_q;
    assign calc_start    = calc_start_q;
    assign cfg_16bits_ia = cfg_16bits_ia_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_err       = rsp_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            calc_start_q    <= 1'b0;
            cfg_16bits_ia_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_tag_q       <= '0;
            rsp_err_q       <= 2'b00;
            drain_pending_q <= 1'b0;
            tmo_cnt_q       <= '0;
`ifdef MMA_LAUNCH_PERF_EN
            perf_last_cycles_q <= '0;
            perf_launch_cnt_q  <= '0;
`endif
        end else begin
            calc_start_q <= 1'b0;
            // A drained beat is swallowed here; the FSM never sees it.
            if (drain_pending_q && wb_valid) begin
                drain_pending_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        rsp_tag_q       <= req_tag;
                        cfg_16bits_ia_q <= req_16bits_ia;
                        state_q         <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (sa_ready) begin
                        calc_start_q <= 1'b1;
                        tmo_cnt_q    <= '0;
                        state_q      <= ST_BUSY;
`ifdef MMA_LAUNCH_PERF_EN
                        perf_launch_cnt_q <= perf_launch_cnt_q + 1'b1;
`endif
                    end
                end
                ST_BUSY: begin
                    if (wb_valid && wb_ready) begin
                        rsp_err_q   <= err_code;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
`ifdef MMA_LAUNCH_PERF_EN
                        perf_last_cycles_q <= tmo_cnt_q;
`endif
                    end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
                        rsp_err_q       <= 2'b11;
                        rsp_valid_q     <= 1'b1;
                        drain_pending_q <= 1'b1;
                        state_q         <= ST_RESP;
                    end else if (tmo_cnt_q != CNT_MAX) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MMA_LAUNCH_PERF_EN
    assign perf_last_cycles = perf_last_cycles_q;
    assign perf_launch_cnt  = perf_launch_cnt_q;
`else
    assign perf_last_cycles = '0;
    assign perf_launch_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mma_launch_ctrl.sv
// ============================================================================
// Module   : tb_mma_launch_ctrl
// Purpose  : Directed and randomized transactions against a transaction-level
//            model of the launch sequencer (timeout = 16 cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mma_launch_ctrl;

    localparam int TW  = 5;
    localparam int CW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [TW-1:0] req_tag;
    logic          req_16bits_ia;
    logic          cfg_16bits_ia;
    logic          calc_start;
    logic          sa_ready;
    logic          wb_valid;
    logic          wb_ready;
    logic [1:0]    err_code;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [TW-1:0] rsp_tag;
    logic [1:0]    rsp_err;
    logic          busy;
    logic [CW-1:0] perf_last_cycles;
    logic [CW-1:0] perf_launch_cnt;

    int checks   = 0;
    int failures = 0;

    int exp_launches = 0;
    int exp_last     = 0;

    mma_launch_ctrl #(
        .TAG_WIDTH      (TW),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_tag          (req_tag),
        .req_16bits_ia    (req_16bits_ia),
        .cfg_16bits_ia    (cfg_16bits_ia),
        .calc_start       (calc_start),
        .sa_ready         (sa_ready),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .err_code         (err_code),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_tag          (rsp_tag),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .perf_last_cycles (perf_last_cycles),
        .perf_launch_cnt  (perf_launch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf();
`ifdef MMA_LAUNCH_PERF_EN
        check("perf_launch_cnt", perf_launch_cnt, exp_launches);
        check("perf_last_cycles", perf_last_cycles, exp_last);
`else
        check("perf_launch_cnt_off", perf_launch_cnt, 32'd0);
        check("perf_last_cycles_off", perf_last_cycles, 32'd0);
`endif
    endtask

    // One full launch. lat = BUSY cycles after the calc_start cycle before the
    // engine answers; answers at or beyond TMO-1 cycles lose to the timeout
    // unless they land exactly on the last allowed cycle.
    task automatic txn(input logic [TW-1:0] tag, input logic ia, input int sa_dly,
                       input int lat, input logic [1:0] err, input int rsp_dly);
        bit          timed_out;
        int          n_busy;
        logic [1:0]  exp_err;
        timed_out = (lat > TMO - 1);
        n_busy    = timed_out ? TMO - 1 : lat;
        exp_err   = timed_out ? 2'b11 : err;

        check("idle_req_ready", req_ready, 1'b1);
        req_valid     = 1'b1;
        req_tag       = tag;
        req_16bits_ia = ia;
        sa_ready      = (sa_dly == 0);
        tick();
        req_valid     = 1'b0;
        req_tag       = ~tag;
        req_16bits_ia = ~ia;
        check("accept_no_start", calc_start, 1'b0);
        check("accept_busy", busy, 1'b1);
        check("cfg_16bits_ia", cfg_16bits_ia, ia);
        check("wait_req_ready", req_ready, 1'b0);
        if (sa_dly > 0) begin
            for (int i = 0; i < sa_dly; i++) begin
                tick();
                check("wait_no_start", calc_start, 1'b0);
                check("wait_busy", busy, 1'b1);
                check("wait_wb_ready", wb_ready, 1'b0);
            end
            sa_ready = 1'b1;
        end
        tick();
        check("calc_start_pulse", calc_start, 1'b1);
        exp_launches++;
        sa_ready = 1'($urandom);

        for (int i = 0; i < n_busy; i++) begin
            check("busy_wb_ready", wb_ready, 1'b1);
            check("busy_no_rsp", rsp_valid, 1'b0);
            tick();
            check("start_single", calc_start, 1'b0);
        end
        if (!timed_out) begin
            wb_valid = 1'b1;
            err_code = err;
        end
        tick();
        wb_valid = 1'b0;
        err_code = 2'($urandom);
        if (!timed_out) exp_last = lat;

        for (int i = 0; i <= rsp_dly; i++) begin
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_tag", rsp_tag, tag);
            check("rsp_err", rsp_err, exp_err);
            check("rsp_req_ready", req_ready, 1'b0);
            check("rsp_wb_ready", wb_ready, timed_out);
            check("rsp_calc_start", calc_start, 1'b0);
            if (i < rsp_dly) begin
                rsp_ready = 1'b0;
                // Stray beat without drain must be ignored.
                if (!timed_out) wb_valid = 1'($urandom);
                tick();
                wb_valid = 1'b0;
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 1'b0);
        check_perf();

        if (timed_out) begin
            check("drain_req_ready", req_ready, 1'b0);
            check("drain_busy", busy, 1'b1);
            req_valid = 1'b1;
            req_tag   = 5'd31;
            tick();
            req_valid = 1'b0;
            check("drain_blocked_start", calc_start, 1'b0);
            check("drain_blocked_ready", req_ready, 1'b0);
            check("drain_wb_ready", wb_ready, 1'b1);
            wb_valid = 1'b1;
            err_code = 2'b00;
            tick();
            wb_valid = 1'b0;
            check("drain_done_rsp", rsp_valid, 1'b0);
        end
        check("end_req_ready", req_ready, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_wb_ready", wb_ready, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_tag       = '0;
        req_16bits_ia = 1'b0;
        sa_ready      = 1'b0;
        wb_valid      = 1'b0;
        err_code      = 2'b00;
        rsp_ready     = 1'b0;
        tick();
        tick();
        check("rst_calc_start", calc_start, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_wb_ready", wb_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        check("por_req_ready", req_ready, 1'b1);
        check("por_wb_ready", wb_ready, 1'b0);
        check("por_cfg", cfg_16bits_ia, 1'b0);
        check("por_rsp_tag", rsp_tag, 5'd0);
        check("por_rsp_err", rsp_err, 2'b00);
        check_perf();

        txn(5'd5, 1'b1, 0, 10, 2'b00, 0);
        txn(5'd9, 1'b0, 20, 3, 2'b10, 0);
        txn(5'd12, 1'b1, 0, 4, 2'b01, 5);
        txn(5'd17, 1'b0, 0, 40, 2'b00, 2);
        txn(5'd3, 1'b1, 1, TMO - 1, 2'b10, 1);
        txn(5'd21, 1'b0, 0, 0, 2'b00, 0);
        txn(5'd22, 1'b1, 0, 0, 2'b01, 0);

        // Reset while BUSY
        req_valid = 1'b1;
        req_tag   = 5'd7;
        sa_ready  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_start", calc_start, 1'b1);
        tick();
        check("pre_rst_wb_ready", wb_ready, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_wb_ready", wb_ready, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_calc_start", calc_start, 1'b0);
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check("rst_mid_wb_ready", wb_ready, 1'b0);
        check("rst_mid_req_ready", req_ready, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        exp_launches = 0;
        exp_last     = 0;
        check_perf();

        for (int n = 0; n < 14; n++) begin
            txn(5'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 22)), 2'($urandom), int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
